// File: rtl/axis_circular_bram_reader_pkg.sv
// Shared definitions for the circular BRAM read-back path.
package axis_circular_bram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Cycles from address to valid read data on BRAM port A.
    localparam int BRAM_RD_LAT = 1;

    // Entries in the output skid buffer.
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axis_circular_bram_reader_skid.sv
// Two-entry data+tlast FIFO. Its head drives the AXI4-Stream outputs; the
// occupancy feeds the read-credit calculation in the top level.
module axis_skid_buffer2
    import axis_circular_bram_reader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         head_ready,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         head_last,
    output logic [1:0]   occupancy
);

    logic [W-1:0] d0, d1;
    logic         l0, l1;
    logic [1:0]   occ_q;
    logic         pop;

    assign head_valid = (occ_q != 2'd0);
    assign head_data  = d0;
    // Entry 1 can hold a stale tlast after draining, so mask it when empty.
    assign head_last  = l0 & head_valid;
    assign occupancy  = occ_q;
    assign pop        = head_valid & head_ready;

    // Entry 0 is always the oldest word; entry 1 only fills when 0 is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0    <= '0;
            d1    <= '0;
            l0    <= 1'b0;
            l1    <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            unique case ({push_valid, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        d0    <= push_data;
                        l0    <= push_last;
                        occ_q <= 2'd1;
                    end else if (occ_q < 2'(SKID_DEPTH)) begin
                        d1    <= push_data;
                        l1    <= push_last;
                        occ_q <= 2'd2;
                    end
                end
                2'b01: begin
                    d0    <= d1;
                    l0    <= l1;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        d0 <= push_data;
                        l0 <= push_last;
                    end else begin
                        d0 <= d1;
                        l0 <= l1;
                        d1 <= push_data;
                        l1 <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_circular_bram_reader.sv
// Reads the circular capture BRAM in time order, starting cfg_pre words before
// the trigger, and emits the words as a single AXI4-Stream packet.
module axis_circular_bram_reader
    import axis_circular_bram_reader_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 16,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       trigger_pos,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_pre,
    input  logic [BRAM_ADDR_WIDTH:0]    cfg_len,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast
);

    localparam int             AW       = BRAM_ADDR_WIDTH;
    localparam logic [AW:0]    DEPTH    = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0]  ADDR_ONE = AW'(1);
    localparam logic [AW:0]    LEN_ONE  = (AW+1)'(1);

    state_t                    state, state_nxt;
    logic [AW-1:0]             addr_q, start_addr;
    logic [AW:0]               remaining, len_eff;
    logic [BRAM_RD_LAT-1:0]    rd_pipe, rd_last_pipe;
    logic                      busy_q, done_q;
    logic                      accept, issue, finish;
    logic [3:0]                fill;
    logic [1:0]                occ;
    logic                      head_valid, head_last, pop;
    logic [AXIS_TDATA_WIDTH-1:0] head_data;
    logic                      unused_bits;

    // Only the low address bits of the capture counter matter.
    generate
        if (CNTR_WIDTH > AW) begin : g_hi_bits
            assign unused_bits = ^trigger_pos[CNTR_WIDTH-1:AW];
        end else begin : g_no_hi_bits
            assign unused_bits = 1'b0;
        end
    endgenerate

    // Packet geometry from the live config; only used at the accept cycle.
    always_comb begin
        start_addr = trigger_pos[AW-1:0] - cfg_pre;
        len_eff    = (cfg_len > DEPTH) ? DEPTH : cfg_len;
    end

    assign pop = head_valid & m_axis_tready;

    // Words that will occupy the skid once every read in flight has landed.
    // A pop this cycle frees a slot in time, which keeps 1 beat/cycle.
    always_comb begin
        fill = 4'(occ);
        for (int i = 0; i < BRAM_RD_LAT; i++) begin
            fill = fill + 4'(rd_pipe[i]);
        end
        fill = fill - 4'(pop);
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        finish    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len_eff != '0) state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (remaining != '0 && fill < 4'(SKID_DEPTH)) begin
                    issue = 1'b1;
                    if (remaining == LEN_ONE) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Address/length counters, read-tag pipe and status flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q       <= '0;
            remaining    <= '0;
            rd_pipe      <= '0;
            rd_last_pipe <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            rd_pipe[0]      <= issue;
            rd_last_pipe[0] <= issue && (remaining == LEN_ONE);
            for (int i = 1; i < BRAM_RD_LAT; i++) begin
                rd_pipe[i]      <= rd_pipe[i-1];
                rd_last_pipe[i] <= rd_last_pipe[i-1];
            end
            if (accept) begin
                done_q <= (len_eff == '0);
                if (len_eff != '0) begin
                    busy_q    <= 1'b1;
                    addr_q    <= start_addr;
                    remaining <= len_eff;
                end
            end
            if (issue) begin
                addr_q    <= addr_q + ADDR_ONE;
                remaining <= remaining - LEN_ONE;
            end
            if (finish) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    axis_skid_buffer2 #(
        .W (AXIS_TDATA_WIDTH)
    ) u_skid (
        .clk        (aclk),
        .rst_n      (aresetn),
        .push_valid (rd_pipe[BRAM_RD_LAT-1]),
        .push_data  (AXIS_TDATA_WIDTH'(bram_porta_rddata)),
        .push_last  (rd_last_pipe[BRAM_RD_LAT-1]),
        .head_ready (m_axis_tready),
        .head_valid (head_valid),
        .head_data  (head_data),
        .head_last  (head_last),
        .occupancy  (occ)
    );

    assign busy            = busy_q;
    assign done            = done_q;
    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = addr_q;
    assign m_axis_tvalid   = head_valid;
    assign m_axis_tdata    = head_data;
    assign m_axis_tlast    = head_last;

endmodule

// File: tb/tb_axis_circular_bram_reader.sv
// Bench for the circular BRAM reader: a queue-based packet model checked
// against every accepted beat, plus literal expectations for fixed cases.
module tb_axis_circular_bram_reader;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [CW-1:0] trigger_pos = '0;
    logic [AW-1:0] cfg_pre = '0;
    logic [AW:0]   cfg_len = '0;
    logic          start = 1'b0;
    logic          busy, done;
    logic          bram_clk, bram_rst;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rddata = '0;
    logic          tready = 1'b0;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast;

    axis_circular_bram_reader #(
        .AXIS_TDATA_WIDTH (DW),
        .BRAM_DATA_WIDTH  (DW),
        .BRAM_ADDR_WIDTH  (AW),
        .CNTR_WIDTH       (CW)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .trigger_pos       (trigger_pos),
        .cfg_pre           (cfg_pre),
        .cfg_len           (cfg_len),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .bram_porta_clk    (bram_clk),
        .bram_porta_rst    (bram_rst),
        .bram_porta_addr   (bram_addr),
        .bram_porta_rddata (bram_rddata),
        .m_axis_tready     (tready),
        .m_axis_tdata      (tdata),
        .m_axis_tvalid     (tvalid),
        .m_axis_tlast      (tlast)
    );

    always #5 aclk = ~aclk;

    logic [DW-1:0] mem [DEPTH];

    // Synchronous-read BRAM: data one cycle after the address.
    always @(posedge aclk) bram_rddata <= mem[bram_addr];

    typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
    beat_t exp_q[$];

    int checks = 0, errors = 0;
    int beats = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
    logic [DW-1:0] first_d = '0, last_d = '0;
    int rdy_mode = 0, stall_left = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected packet: len clipped to the buffer depth, start wrapped modulo depth.
    task automatic load_model(input logic [31:0] tp, input int pre, input int len, output int n);
        int s;
        beat_t b;
        n = (len > DEPTH) ? DEPTH : len;
        s = (int'(tp % 32'd16) - pre + DEPTH) % DEPTH;
        for (int i = 0; i < n; i++) begin
            b.d = mem[(s + i) % DEPTH];
            b.l = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    // Downstream ready: always-on, or 50% random with an optional stall on beat 3.
    initial forever begin
        @(posedge aclk);
        #1;
        if (rdy_mode == 0) tready = 1'b1;
        else if (stall_left > 0 && beats == 2 && tvalid) begin
            tready = 1'b0;
            stall_left--;
        end else tready = 1'($urandom_range(0, 1));
    end

    // Every accepted beat is checked against the model; held beats must not change.
    initial begin : compare
        logic hold;
        logic [DW-1:0] hold_d;
        logic hold_l;
        beat_t e;
        hold = 1'b0;
        hold_d = '0;
        hold_l = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) hold = 1'b0;
            else begin
                if (hold) begin
                    chk("hold_valid", 64'(tvalid), 64'(1));
                    chk("hold_data", 64'(tdata), 64'(hold_d));
                    chk("hold_last", 64'(tlast), 64'(hold_l));
                end
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat: got %0h want no beat", tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 64'(tdata), 64'(e.d));
                        chk("beat_last", 64'(tlast), 64'(e.l));
                    end
                    if (beats == 0) begin
                        first_cyc = cyc;
                        first_d = tdata;
                    end
                    last_cyc = cyc;
                    last_d = tdata;
                    beats++;
                end
                hold = tvalid && !tready;
                hold_d = tdata;
                hold_l = tlast;
            end
        end
    end

    task automatic begin_pkt(input logic [31:0] tp, input int pre, input int len, output int n);
        beats = 0;
        @(posedge aclk);
        #1;
        trigger_pos = tp;
        cfg_pre = AW'(pre);
        cfg_len = (AW+1)'(len);
        start = 1'b1;
        load_model(tp, pre, len, n);
        @(posedge aclk);
        #1;
        start = 1'b0;
        // Config changes after accept must not affect the packet.
        trigger_pos = $urandom;
        cfg_pre = AW'($urandom);
        cfg_len = (AW+1)'($urandom);
        chk("busy_accept", 64'(busy), 64'(n != 0));
        chk("done_accept", 64'(done), 64'(n == 0));
        chk("tvalid_lat0", 64'(tvalid), 64'(0));
    endtask

    task automatic run_pkt(input logic [31:0] tp, input int pre, input int len);
        int n;
        bit ok;
        begin_pkt(tp, pre, len, n);
        if (n != 0) begin
            @(posedge aclk); #1;
            chk("tvalid_lat1", 64'(tvalid), 64'(0));
            @(posedge aclk); #1;
            chk("tvalid_lat2", 64'(tvalid), 64'(1));
        end
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge aclk); #1;
        end
        chk("done_timeout", 64'(ok), 64'(1));
        repeat (3) begin
            @(posedge aclk); #1;
        end
        chk("busy_end", 64'(busy), 64'(0));
        chk("done_end", 64'(done), 64'(1));
        chk("tvalid_end", 64'(tvalid), 64'(0));
        chk("beat_count", 64'(beats), 64'(n));
        chk("model_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : main
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = {8'(i), 24'($urandom)};

        rdy_mode = 0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_tvalid", 64'(tvalid), 64'(0));
        chk("rst_tlast", 64'(tlast), 64'(0));
        chk("rst_addr", 64'(bram_addr), 64'(0));
        chk("rst_bram_rst", 64'(bram_rst), 64'(1));
        aresetn = 1'b1;

        // Plain read: addresses 7..14, back-to-back beats.
        run_pkt(32'd10, 3, 8);
        chk("t1_first", 64'(first_d), 64'(mem[7]));
        chk("t1_last", 64'(last_d), 64'(mem[14]));
        chk("t1_span", 64'(last_cyc - first_cyc), 64'(7));

        // Wrap: 13,14,15,0,1,2.
        run_pkt(32'd2, 5, 6);
        chk("t2_first", 64'(first_d), 64'(mem[13]));
        chk("t2_last", 64'(last_d), 64'(mem[2]));
        chk("t2_beats", 64'(beats), 64'(6));

        // Oversized length clips to the full buffer, ending at start-1.
        run_pkt(32'd5, 0, 20);
        chk("t3_beats", 64'(beats), 64'(16));
        chk("t3_first", 64'(first_d), 64'(mem[5]));
        chk("t3_last", 64'(last_d), 64'(mem[4]));

        // Random backpressure with a 5-cycle stall on beat 3.
        rdy_mode = 1;
        stall_left = 5;
        run_pkt(32'd9, 1, 12);
        chk("t4_stalled", 64'(stall_left), 64'(0));
        rdy_mode = 0;

        // Zero length, then a short packet.
        run_pkt(32'd3, 1, 0);
        chk("t5_zero_beats", 64'(beats), 64'(0));
        run_pkt(32'd3, 1, 4);
        chk("t5_beats", 64'(beats), 64'(4));
        chk("t5_last", 64'(last_d), 64'(mem[5]));

        // Reset in the middle of a packet.
        begin_pkt(32'd0, 0, 8, n);
        for (int k = 0; k < 50; k++) begin
            if (beats >= 2) break;
            @(posedge aclk); #1;
        end
        chk("t6_reached_beat2", 64'(beats >= 2), 64'(1));
        aresetn = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(tvalid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_done", 64'(done), 64'(0));
        chk("t6_rst_tlast", 64'(tlast), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        run_pkt(32'd0, 0, 8);
        chk("t6_beats", 64'(beats), 64'(8));
        chk("t6_first", 64'(first_d), 64'(mem[0]));

        // Random packets, alternating ready behaviour.
        for (int r = 0; r < 10; r++) begin
            rdy_mode = r % 2;
            run_pkt($urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

endmodule
